mem_req_bridge: RTL and testbench

//  Parametrised successor to the core's fixed inst/data SRAM hookup: NCH core-side SRAM-style channels
//  (stall-based) merged onto one pipelined sram-like master port (req/addr_ok/data_ok).

---
 rtl/mem_bridge_pkg.sv | 27 ++
 rtl/mem_req_bridge_if.sv | 25 ++
 rtl/mem_bridge_tag_fifo.sv | 56 +++++
 rtl/mem_req_bridge.sv | 155 +++++++++++++++
 tb/tb_mem_req_bridge.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the memory request bridge: channel state encoding,
// access size codes and the kseg0/kseg1 window used by the optional address map.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_PEND = 2'd1,
        CH_WAIT = 2'd2
    } ch_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [2:0]  KSEG0_BASE = 3'b100;
    localparam logic [2:0]  KSEG1_BASE = 3'b101;
    localparam logic [31:0] KSEG_MASK  = 32'h1FFF_FFFF;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical space
    function automatic logic [31:0] kseg_map(input logic [31:0] va);
        if ((va[31:29] == KSEG0_BASE) || (va[31:29] == KSEG1_BASE)) begin
            return va & KSEG_MASK;
        end
        return va;
    endfunction

endpackage

// File: rtl/mem_req_bridge_if.sv
// Pipelined sram-like master port: req/addr_ok request phase, in-order data_ok responses.
interface mem_req_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [3:0]    wstrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [DW-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_bridge_tag_fifo.sv
// Outstanding-transaction tag FIFO: records which channel owns each accepted
// master request so in-order responses can be routed back.
module mem_bridge_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int TW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [TW-1:0] push_tag,
    input  logic          pop,
    output logic [TW-1:0] head_tag,
    output logic          full,
    output logic          empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [TW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_tag = mem[rd_ptr];

    // tag storage needs no reset: entries are only read once pushed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    // pointers and occupancy; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_bridge.sv
// Merges NCH stall-based core channels onto one pipelined sram-like master port.
// Round-robin arbitration, in-order response routing via the tag FIFO.
// Optional macro MEM_BRIDGE_KSEG_MAP_EN: fold kseg0/kseg1 addresses to physical at capture.
module mem_req_bridge
    import mem_bridge_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int OUTST = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_wr,
    input  logic [2*NCH-1:0]  ch_size,
    input  logic [4*NCH-1:0]  ch_wstrb,
    input  logic [AW*NCH-1:0] ch_addr,
    input  logic [DW*NCH-1:0] ch_wdata,
    output logic [NCH-1:0]    ch_stall,
    output logic [NCH-1:0]    ch_rvalid,
    output logic [DW*NCH-1:0] ch_rdata,
    mem_req_bridge_if.master  m,
    output logic              protocol_err
);
    localparam int TW = (NCH > 1) ? $clog2(NCH) : 1;

    ch_state_t     st         [NCH];
    logic          slot_wr    [NCH];
    logic [1:0]    slot_size  [NCH];
    logic [3:0]    slot_wstrb [NCH];
    logic [AW-1:0] slot_addr  [NCH];
    logic [DW-1:0] slot_wdata [NCH];

    logic [TW-1:0] rr_ptr;
    logic [TW-1:0] grant;
    logic [TW-1:0] lock_idx;
    logic          lock_vld;
    logic          any_pend;
    logic          hs;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [TW-1:0] head_tag;

`ifdef MEM_BRIDGE_KSEG_MAP_EN
    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] va);
        return kseg_map(va);
    endfunction
`else
    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] va);
        return va;
    endfunction
`endif

    // round-robin pick from rr_ptr; a grant refused by addr_ok stays locked until accepted
    always_comb begin
        any_pend = 1'b0;
        grant    = rr_ptr;
        for (int k = 0; k < NCH; k++) begin
            if (!any_pend && (st[(int'(rr_ptr) + k) % NCH] == CH_PEND)) begin
                any_pend = 1'b1;
                grant    = TW'((int'(rr_ptr) + k) % NCH);
            end
        end
        if (lock_vld) grant = lock_idx;
    end

    assign m.req   = any_pend & ~fifo_full;
    assign m.wr    = slot_wr[grant];
    assign m.size  = slot_size[grant];
    assign m.wstrb = slot_wstrb[grant];
    assign m.addr  = slot_addr[grant];
    assign m.wdata = slot_wdata[grant];

    assign hs  = m.req & m.addr_ok;
    assign pop = m.data_ok & ~fifo_empty;

    assign ch_rdata = {NCH{m.rdata}};

    // route each popped response to the channel recorded at the FIFO head
    always_comb begin
        ch_rvalid = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_rvalid[i] = pop && (head_tag == TW'(i));
        end
    end

    // stall until the cycle the channel's response arrives
    always_comb begin
        ch_stall = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_stall[i] = ((st[i] == CH_IDLE) && ch_req[i]) ||
                          (st[i] == CH_PEND) ||
                          ((st[i] == CH_WAIT) && !ch_rvalid[i]);
        end
    end

    // per-channel FSM; request fields are captured on leaving IDLE and frozen until back
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) st[i] <= CH_IDLE;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (st[i])
                    CH_IDLE: if (ch_req[i]) begin
                        st[i]         <= CH_PEND;
                        slot_wr[i]    <= ch_wr[i];
                        slot_size[i]  <= ch_size[2*i +: 2];
                        slot_wstrb[i] <= ch_wstrb[4*i +: 4];
                        slot_addr[i]  <= map_addr(ch_addr[AW*i +: AW]);
                        slot_wdata[i] <= ch_wdata[DW*i +: DW];
                    end
                    CH_PEND: if (hs && (grant == TW'(i))) st[i] <= CH_WAIT;
                    CH_WAIT: if (ch_rvalid[i]) st[i] <= CH_IDLE;
                    default: st[i] <= CH_IDLE;
                endcase
            end
        end
    end

    // arbiter pointer, grant lock and sticky protocol error
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            lock_vld     <= 1'b0;
            lock_idx     <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (hs) begin
                rr_ptr   <= (grant == TW'(NCH - 1)) ? '0 : grant + 1'b1;
                lock_vld <= 1'b0;
            end else if (m.req) begin
                lock_vld <= 1'b1;
                lock_idx <= grant;
            end
            if (m.data_ok && fifo_empty) protocol_err <= 1'b1;
        end
    end

    mem_bridge_tag_fifo #(
        .DEPTH (OUTST),
        .TW    (TW)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (hs),
        .push_tag (grant),
        .pop      (pop),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_mem_req_bridge.sv
// Bench for mem_req_bridge: directed scenarios followed by random traffic, all
// checked every cycle against a queue-based behavioural model of the bridge.
module tb_mem_req_bridge;
    import mem_bridge_pkg::*;

    localparam int NCH   = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int OUTST = 2;

`ifdef MEM_BRIDGE_KSEG_MAP_EN
    localparam logic [AW-1:0] T1_MADDR = 32'h1FC0_0000;
`else
    localparam logic [AW-1:0] T1_MADDR = 32'h9FC0_0000;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_req, ch_wr, ch_stall, ch_rvalid;
    logic [2*NCH-1:0]  ch_size;
    logic [4*NCH-1:0]  ch_wstrb;
    logic [AW*NCH-1:0] ch_addr;
    logic [DW*NCH-1:0] ch_wdata, ch_rdata;
    logic              protocol_err;

    mem_req_bridge_if #(.AW(AW), .DW(DW)) mif ();

    mem_req_bridge #(.NCH(NCH), .AW(AW), .DW(DW), .OUTST(OUTST)) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_req       (ch_req),
        .ch_wr        (ch_wr),
        .ch_size      (ch_size),
        .ch_wstrb     (ch_wstrb),
        .ch_addr      (ch_addr),
        .ch_wdata     (ch_wdata),
        .ch_stall     (ch_stall),
        .ch_rvalid    (ch_rvalid),
        .ch_rdata     (ch_rdata),
        .m            (mif),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    // reference model: per-channel pending/waiting flags, captured requests, owner queue
    bit            md_pend  [NCH];
    bit            md_wait  [NCH];
    logic          md_wr    [NCH];
    logic [1:0]    md_size  [NCH];
    logic [3:0]    md_wstrb [NCH];
    logic [AW-1:0] md_addr  [NCH];
    logic [DW-1:0] md_wdata [NCH];
    int            md_outq  [$];
    int            md_rr;
    int            md_held;
    bit            md_perr;

    int n_assert = 0;
    int n_fail   = 0;

    logic           o_mreq, o_perr;
    logic [NCH-1:0] o_stall, o_rvalid;
    logic [AW-1:0]  o_addr;
    logic [DW-1:0]  o_rdata0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_map(input logic [AW-1:0] a);
`ifdef MEM_BRIDGE_KSEG_MAP_EN
        if (a[31:30] == 2'b10) return {3'b000, a[28:0]};
`endif
        return a;
    endfunction

    task automatic clear_inputs();
        ch_req = '0; ch_wr = '0; ch_size = '0; ch_wstrb = '0;
        ch_addr = '0; ch_wdata = '0;
        mif.addr_ok = 1'b0; mif.data_ok = 1'b0; mif.rdata = '0;
    endtask

    task automatic set_ch(input int c, input logic wr, input logic [1:0] sz,
                          input logic [3:0] ws, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_req[c] = 1'b1;
        ch_wr[c] = wr;
        ch_size[2*c +: 2] = sz;
        ch_wstrb[4*c +: 4] = ws;
        ch_addr[AW*c +: AW] = a;
        ch_wdata[DW*c +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            md_pend[c] = 1'b0;
            md_wait[c] = 1'b0;
        end
        md_outq.delete();
        md_rr = 0;
        md_held = -1;
        md_perr = 1'b0;
    endtask

    // one clock: check all outputs against the model at negedge, advance the model
    task automatic run_cycle();
        bit any_pend;
        bit exp_req;
        int g;
        int popped;
        logic [NCH-1:0] exp_rv;
        logic [NCH-1:0] exp_st;
        @(negedge clk);
        o_mreq = mif.req; o_perr = protocol_err; o_stall = ch_stall;
        o_rvalid = ch_rvalid; o_addr = mif.addr; o_rdata0 = ch_rdata[DW-1:0];

        any_pend = 1'b0;
        for (int c = 0; c < NCH; c++) if (md_pend[c]) any_pend = 1'b1;
        exp_req = any_pend && (md_outq.size() < OUTST);
        chk("m_req", mif.req, exp_req);

        g = -1;
        if (exp_req) begin
            if (md_held >= 0) g = md_held;
            else for (int k = 0; k < NCH; k++)
                if (g < 0 && md_pend[(md_rr + k) % NCH]) g = (md_rr + k) % NCH;
            chk("m_addr", mif.addr, exp_map(md_addr[g]));
            chk("m_wr", mif.wr, md_wr[g]);
            chk("m_size", mif.size, md_size[g]);
            chk("m_wstrb", mif.wstrb, md_wstrb[g]);
            chk("m_wdata", mif.wdata, md_wdata[g]);
        end

        chk("protocol_err", protocol_err, md_perr);

        popped = -1;
        exp_rv = '0;
        if (mif.data_ok) begin
            if (md_outq.size() > 0) begin
                popped = md_outq.pop_front();
                exp_rv[popped] = 1'b1;
                chk("ch_rdata", ch_rdata[popped*DW +: DW], mif.rdata);
            end else begin
                md_perr = 1'b1;
            end
        end
        chk("ch_rvalid", ch_rvalid, exp_rv);

        for (int c = 0; c < NCH; c++)
            exp_st[c] = (!md_pend[c] && !md_wait[c] && ch_req[c]) || md_pend[c] ||
                        (md_wait[c] && !exp_rv[c]);
        chk("ch_stall", ch_stall, exp_st);

        for (int c = 0; c < NCH; c++) begin
            if (!md_pend[c] && !md_wait[c] && ch_req[c]) begin
                md_pend[c]  = 1'b1;
                md_wr[c]    = ch_wr[c];
                md_size[c]  = ch_size[2*c +: 2];
                md_wstrb[c] = ch_wstrb[4*c +: 4];
                md_addr[c]  = ch_addr[AW*c +: AW];
                md_wdata[c] = ch_wdata[DW*c +: DW];
            end
        end
        if (exp_req && mif.addr_ok) begin
            md_pend[g] = 1'b0;
            md_wait[g] = 1'b1;
            md_outq.push_back(g);
            md_rr = (g + 1) % NCH;
            md_held = -1;
        end else if (exp_req) begin
            md_held = g;
        end
        if (popped >= 0) md_wait[popped] = 1'b0;

        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // reset state
        do_reset();
        run_cycle();
        chk("rst_stall", o_stall, 3'b000);
        chk("rst_mreq", o_mreq, 1'b0);
        chk("rst_perr", o_perr, 1'b0);
        chk("rst_rvalid", o_rvalid, 3'b000);

        // T1: single read at minimum latency, kseg address
        set_ch(0, 1'b0, SIZE_WORD, 4'h0, 32'h9FC0_0000, 32'h0);
        mif.addr_ok = 1'b1;
        run_cycle();
        chk("t1_c0_stall", o_stall[0], 1'b1);
        chk("t1_c0_mreq", o_mreq, 1'b0);
        ch_req = '0;
        run_cycle();
        chk("t1_c1_mreq", o_mreq, 1'b1);
        chk("t1_c1_maddr", o_addr, T1_MADDR);
        chk("t1_c1_stall", o_stall[0], 1'b1);
        mif.data_ok = 1'b1; mif.rdata = 32'h1234_5678;
        run_cycle();
        chk("t1_c2_rvalid", o_rvalid, 3'b001);
        chk("t1_c2_rdata", o_rdata0, 32'h1234_5678);
        chk("t1_c2_stall", o_stall[0], 1'b0);
        mif.data_ok = 1'b0;
        run_cycle();

        // T2: two channels in the same cycle, ordered grants and responses
        do_reset();
        set_ch(0, 1'b0, SIZE_WORD, 4'h0, 32'h0000_0100, 32'h0);
        set_ch(1, 1'b1, SIZE_HALF, 4'h3, 32'h0000_0200, 32'hCAFE_0001);
        mif.addr_ok = 1'b1;
        run_cycle();
        ch_req = '0;
        run_cycle();
        chk("t2_c1_addr", o_addr, 32'h0000_0100);
        mif.data_ok = 1'b1; mif.rdata = 32'hAAAA_0000;
        run_cycle();
        chk("t2_c2_addr", o_addr, 32'h0000_0200);
        chk("t2_c2_rvalid", o_rvalid, 3'b001);
        mif.rdata = 32'hBBBB_1111;
        run_cycle();
        chk("t2_c3_rvalid", o_rvalid, 3'b010);
        mif.data_ok = 1'b0;
        run_cycle();

        // T3: three channels, two outstanding slots
        do_reset();
        set_ch(0, 1'b0, SIZE_WORD, 4'h0, 32'h0000_1000, 32'h0);
        set_ch(1, 1'b0, SIZE_BYTE, 4'h0, 32'h0000_2000, 32'h0);
        set_ch(2, 1'b1, SIZE_WORD, 4'hF, 32'h0000_3000, 32'h5555_AAAA);
        mif.addr_ok = 1'b1;
        run_cycle();
        ch_req = '0;
        run_cycle();
        chk("t3_c1_addr", o_addr, 32'h0000_1000);
        run_cycle();
        chk("t3_c2_addr", o_addr, 32'h0000_2000);
        run_cycle();
        chk("t3_full_mreq", o_mreq, 1'b0);
        mif.data_ok = 1'b1; mif.rdata = 32'h0101_0101;
        run_cycle();
        chk("t3_pop_mreq", o_mreq, 1'b0);
        chk("t3_pop_rvalid", o_rvalid, 3'b001);
        mif.data_ok = 1'b0;
        run_cycle();
        chk("t3_after_pop_mreq", o_mreq, 1'b1);
        chk("t3_after_pop_addr", o_addr, 32'h0000_3000);
        mif.data_ok = 1'b1; mif.rdata = 32'h0202_0202;
        run_cycle();
        chk("t3_rv_ch1", o_rvalid, 3'b010);
        run_cycle();
        chk("t3_rv_ch2", o_rvalid, 3'b100);
        mif.data_ok = 1'b0;
        run_cycle();

        // T4: addr_ok held low, grant must not move to a later higher-priority request
        do_reset();
        set_ch(1, 1'b1, SIZE_WORD, 4'hF, 32'h0000_4444, 32'h1357_9BDF);
        run_cycle();
        ch_req = '0;
        set_ch(0, 1'b0, SIZE_WORD, 4'h0, 32'h0000_8888, 32'h0);
        for (int n = 0; n < 5; n++) begin
            run_cycle();
            ch_req = '0;
            chk("t4_hold_mreq", o_mreq, 1'b1);
            chk("t4_hold_addr", o_addr, 32'h0000_4444);
            chk("t4_hold_stall", o_stall[1], 1'b1);
        end
        mif.addr_ok = 1'b1;
        run_cycle();
        chk("t4_accept_addr", o_addr, 32'h0000_4444);
        run_cycle();
        chk("t4_next_addr", o_addr, 32'h0000_8888);
        mif.addr_ok = 1'b0; mif.data_ok = 1'b1; mif.rdata = 32'h7777_0000;
        run_cycle();
        run_cycle();
        mif.data_ok = 1'b0;
        run_cycle();

        // T5: data_ok with nothing outstanding
        do_reset();
        mif.data_ok = 1'b1; mif.rdata = 32'hDEAD_BEEF;
        run_cycle();
        chk("t5_rvalid", o_rvalid, 3'b000);
        mif.data_ok = 1'b0;
        for (int n = 0; n < 3; n++) begin
            run_cycle();
            chk("t5_perr_sticky", o_perr, 1'b1);
        end

        // T6: reset while ch1 waits for its response
        set_ch(1, 1'b0, SIZE_WORD, 4'h0, 32'h0000_6000, 32'h0);
        mif.addr_ok = 1'b1;
        run_cycle();
        ch_req = '0;
        run_cycle();
        mif.addr_ok = 1'b0;
        run_cycle();
        chk("t6_wait_stall", o_stall[1], 1'b1);
        do_reset();
        run_cycle();
        chk("t6_stall", o_stall, 3'b000);
        chk("t6_mreq", o_mreq, 1'b0);
        chk("t6_perr", o_perr, 1'b0);
        mif.data_ok = 1'b1;
        run_cycle();
        mif.data_ok = 1'b0;
        run_cycle();
        chk("t6_fifo_empty", o_perr, 1'b1);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NCH; c++) begin
                ch_req[c] = ($urandom_range(0, 2) == 0);
                ch_wr[c] = ($urandom_range(0, 1) == 1);
                ch_size[2*c +: 2] = 2'($urandom_range(0, 2));
                ch_wstrb[4*c +: 4] = 4'($urandom);
                ch_addr[AW*c +: AW] = $urandom;
                ch_wdata[DW*c +: DW] = $urandom;
            end
            mif.addr_ok = ($urandom_range(0, 3) != 0);
            mif.data_ok = (md_outq.size() > 0) && ($urandom_range(0, 1) == 1);
            mif.rdata = $urandom;
            run_cycle();
        end
        ch_req = '0;
        mif.addr_ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            mif.data_ok = (md_outq.size() > 0);
            mif.rdata = $urandom;
            run_cycle();
        end
        do_reset();
        run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
